// File: rtl/axis_tx_arbiter.sv
// Two-port, frame-atomic AXI-Stream arbiter for a MAC TX path. It also routes
// each TransmitStatus pulse back to the requester that owns the oldest frame.
module axis_tx_arbiter #(
  parameter int STATUS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_axis_data,
  input  logic       s0_axis_valid,
  output logic       s0_axis_ready,
  input  logic       s0_axis_last,
  input  logic       s0_axis_err,
  input  logic [7:0] s1_axis_data,
  input  logic       s1_axis_valid,
  output logic       s1_axis_ready,
  input  logic       s1_axis_last,
  input  logic       s1_axis_err,
  output logic [7:0] m_axis_data,
  output logic       m_axis_valid,
  input  logic       m_axis_ready,
  output logic       m_axis_last,
  output logic       m_axis_err,
  input  logic       transmit_ok,
  input  logic       gave_up,
  input  logic       late_collision,
  input  logic       underflow,
  output logic       s0_status_valid,
  output logic       s1_status_valid,
  output logic [1:0] s0_status,
  output logic [1:0] s1_status,
  output logic       busy,
  output logic       stray_status
);

  localparam int PTR_W = $clog2(STATUS_DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(STATUS_DEPTH);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic             gnt;
  logic             last_port;
  logic             fifo_mem [STATUS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;

  logic       fifo_full;
  logic       fifo_empty;
  logic       any_req;
  logic       next_gnt;
  logic       push;
  logic       any_status;
  logic       pop;
  logic       head_port;
  logic       end_beat;
  logic [1:0] code;

  // Worst outcome wins when the MAC raises several status lines at once.
  function automatic logic [1:0] encode_status(input logic gu, input logic lc, input logic uf);
    if (uf)
      return 2'd3;
    else if (lc)
      return 2'd2;
    else if (gu)
      return 2'd1;
    return 2'd0;
  endfunction

  assign fifo_full  = (occ == FULL_OCC);
  assign fifo_empty = (occ == '0);
  assign any_req    = s0_axis_valid | s1_axis_valid;
  assign next_gnt   = (s0_axis_valid & s1_axis_valid) ? ~last_port : s1_axis_valid;
  assign push       = (state == IDLE) & any_req & ~fifo_full;
  assign any_status = transmit_ok | gave_up | late_collision | underflow;
  assign pop        = any_status & ~fifo_empty;
  assign head_port  = fifo_mem[rd_ptr];
  assign end_beat   = (state == GRANT) & m_axis_valid & m_axis_ready & m_axis_last;
  assign code       = encode_status(gave_up, late_collision, underflow);
  assign busy       = (state == GRANT) | ~fifo_empty;

  always_comb begin
    m_axis_data   = '0;
    m_axis_valid  = 1'b0;
    m_axis_last   = 1'b0;
    m_axis_err    = 1'b0;
    s0_axis_ready = 1'b0;
    s1_axis_ready = 1'b0;
    if (state == GRANT) begin
      if (gnt) begin
        m_axis_data   = s1_axis_data;
        m_axis_valid  = s1_axis_valid;
        m_axis_last   = s1_axis_last;
        m_axis_err    = s1_axis_err;
        s1_axis_ready = m_axis_ready;
      end else begin
        m_axis_data   = s0_axis_data;
        m_axis_valid  = s0_axis_valid;
        m_axis_last   = s0_axis_last;
        m_axis_err    = s0_axis_err;
        s0_axis_ready = m_axis_ready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      gnt             <= 1'b0;
      last_port       <= 1'b1;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occ             <= '0;
      stray_status    <= 1'b0;
      s0_status_valid <= 1'b0;
      s1_status_valid <= 1'b0;
    end else begin
      s0_status_valid <= pop & ~head_port;
      s1_status_valid <= pop & head_port;
      if (any_status & fifo_empty)
        stray_status <= 1'b1;

      case (state)
        IDLE: begin
          if (push) begin
            gnt   <= next_gnt;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (end_beat) begin
            last_port <= gnt;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Data-only registers: owner FIFO entries and the decoded status codes.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= next_gnt;
    if (pop & ~head_port)
      s0_status <= code;
    if (pop & head_port)
      s1_status <= code;
  end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Directed bench for axis_tx_arbiter: a cycle table for arbitration and status
// routing, plus hand-written sequences for long frames, FIFO full, stray and reset.
module tb_axis_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s0_axis_data = '0, s1_axis_data = '0;
  logic       s0_axis_valid = 1'b0, s0_axis_last = 1'b0, s0_axis_err = 1'b0;
  logic       s1_axis_valid = 1'b0, s1_axis_last = 1'b0, s1_axis_err = 1'b0;
  logic       s0_axis_ready, s1_axis_ready;
  logic [7:0] m_axis_data;
  logic       m_axis_valid, m_axis_last, m_axis_err;
  logic       m_axis_ready = 1'b1;
  logic       transmit_ok = 1'b0, gave_up = 1'b0, late_collision = 1'b0, underflow = 1'b0;
  logic       s0_status_valid, s1_status_valid;
  logic [1:0] s0_status, s1_status;
  logic       busy, stray_status;

  int errors = 0;
  int checks = 0;

  axis_tx_arbiter #(.STATUS_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s0_axis_data(s0_axis_data), .s0_axis_valid(s0_axis_valid), .s0_axis_ready(s0_axis_ready),
    .s0_axis_last(s0_axis_last), .s0_axis_err(s0_axis_err),
    .s1_axis_data(s1_axis_data), .s1_axis_valid(s1_axis_valid), .s1_axis_ready(s1_axis_ready),
    .s1_axis_last(s1_axis_last), .s1_axis_err(s1_axis_err),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_last(m_axis_last), .m_axis_err(m_axis_err),
    .transmit_ok(transmit_ok), .gave_up(gave_up), .late_collision(late_collision),
    .underflow(underflow),
    .s0_status_valid(s0_status_valid), .s1_status_valid(s1_status_valid),
    .s0_status(s0_status), .s1_status(s1_status),
    .busy(busy), .stray_status(stray_status)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       s0v, s0l; logic [7:0] s0d;
    logic       s1v, s1l; logic [7:0] s1d;
    logic       mrdy;
    logic [3:0] st;                 // {underflow, late_collision, gave_up, transmit_ok}
    logic       mv, ml; logic [7:0] md;
    logic       r0, r1, bsy, sv0, sv1;
    logic [1:0] stc;
  } vec_t;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam int NV = 23;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_axis_valid = 1'b0; s0_axis_last = 1'b0; s0_axis_data = '0; s0_axis_err = 1'b0;
    s1_axis_valid = 1'b0; s1_axis_last = 1'b0; s1_axis_data = '0; s1_axis_err = 1'b0;
    m_axis_ready = 1'b1;
    {underflow, late_collision, gave_up, transmit_ok} = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int beats, bad, got;

  initial begin
    // Cycle table: frames p0,p1,p0,p1 with a backpressure beat, then status routing.
    tv[0]  = '{T,F,8'h01, T,F,8'h11, T,4'b0000, F,F,8'h00, F,F,F, F,F,2'd0};
    tv[1]  = '{T,F,8'h01, T,F,8'h11, T,4'b0000, T,F,8'h01, T,F,T, F,F,2'd0};
    tv[2]  = '{T,F,8'h02, T,F,8'h11, F,4'b0000, T,F,8'h02, F,F,T, F,F,2'd0};
    tv[3]  = '{T,F,8'h02, T,F,8'h11, T,4'b0000, T,F,8'h02, T,F,T, F,F,2'd0};
    tv[4]  = '{T,T,8'h03, T,F,8'h11, T,4'b0000, T,T,8'h03, T,F,T, F,F,2'd0};
    tv[5]  = '{T,F,8'h81, T,F,8'h11, T,4'b0000, F,F,8'h00, F,F,T, F,F,2'd0};
    tv[6]  = '{T,F,8'h81, T,F,8'h11, T,4'b0000, T,F,8'h11, F,T,T, F,F,2'd0};
    tv[7]  = '{T,F,8'h81, T,F,8'h12, T,4'b0000, T,F,8'h12, F,T,T, F,F,2'd0};
    tv[8]  = '{T,F,8'h81, T,T,8'h13, T,4'b0000, T,T,8'h13, F,T,T, F,F,2'd0};
    tv[9]  = '{T,F,8'h81, T,F,8'h91, T,4'b0000, F,F,8'h00, F,F,T, F,F,2'd0};
    tv[10] = '{T,F,8'h81, T,F,8'h91, T,4'b0000, T,F,8'h81, T,F,T, F,F,2'd0};
    tv[11] = '{T,F,8'h82, T,F,8'h91, T,4'b0000, T,F,8'h82, T,F,T, F,F,2'd0};
    tv[12] = '{T,T,8'h83, T,F,8'h91, T,4'b0000, T,T,8'h83, T,F,T, F,F,2'd0};
    tv[13] = '{F,F,8'h00, T,F,8'h91, T,4'b0000, F,F,8'h00, F,F,T, F,F,2'd0};
    tv[14] = '{F,F,8'h00, T,F,8'h91, T,4'b0000, T,F,8'h91, F,T,T, F,F,2'd0};
    tv[15] = '{F,F,8'h00, T,F,8'h92, T,4'b0000, T,F,8'h92, F,T,T, F,F,2'd0};
    tv[16] = '{F,F,8'h00, T,T,8'h93, T,4'b0000, T,T,8'h93, F,T,T, F,F,2'd0};
    tv[17] = '{F,F,8'h00, F,F,8'h00, T,4'b0010, F,F,8'h00, F,F,T, F,F,2'd0};
    tv[18] = '{F,F,8'h00, F,F,8'h00, T,4'b1100, F,F,8'h00, F,F,T, T,F,2'd1};
    tv[19] = '{F,F,8'h00, F,F,8'h00, T,4'b0001, F,F,8'h00, F,F,T, F,T,2'd3};
    tv[20] = '{F,F,8'h00, F,F,8'h00, T,4'b0011, F,F,8'h00, F,F,T, T,F,2'd0};
    tv[21] = '{F,F,8'h00, F,F,8'h00, T,4'b0000, F,F,8'h00, F,F,F, F,T,2'd1};
    tv[22] = '{F,F,8'h00, F,F,8'h00, T,4'b0000, F,F,8'h00, F,F,F, F,F,2'd0};

    do_reset();
    @(negedge clk);
    chk("reset_state",
        {s0_axis_ready, s1_axis_ready, m_axis_valid, busy, stray_status, s0_status_valid, s1_status_valid},
        7'b0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      s0_axis_valid = tv[i].s0v; s0_axis_last = tv[i].s0l; s0_axis_data = tv[i].s0d;
      s0_axis_err   = tv[i].s0d[7];
      s1_axis_valid = tv[i].s1v; s1_axis_last = tv[i].s1l; s1_axis_data = tv[i].s1d;
      s1_axis_err   = tv[i].s1d[7];
      m_axis_ready  = tv[i].mrdy;
      {underflow, late_collision, gave_up, transmit_ok} = tv[i].st;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {m_axis_valid, m_axis_last, (tv[i].mv ? m_axis_data : 8'h00), (tv[i].mv ? m_axis_err : 1'b0),
           s0_axis_ready, s1_axis_ready, busy, s0_status_valid, s1_status_valid,
           (tv[i].sv0 ? s0_status : (tv[i].sv1 ? s1_status : 2'd0))},
          {tv[i].mv, tv[i].ml, tv[i].md, tv[i].mv & tv[i].md[7],
           tv[i].r0, tv[i].r1, tv[i].bsy, tv[i].sv0, tv[i].sv1, tv[i].stc});
      @(posedge clk); #1;
    end
    chk("no_stray_in_table", stray_status, 0);

    // Long port-1 frame; port 0 requests mid-frame and must wait.
    do_reset();
    s1_axis_valid = 1'b1; s1_axis_data = 8'h00;
    bad = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      s1_axis_data = 8'(k);
      s1_axis_last = (k == 69);
      if (k == 10) begin
        s0_axis_valid = 1'b1; s0_axis_data = 8'hA0; s0_axis_last = 1'b1;
      end
      @(negedge clk);
      if (!(m_axis_valid && m_axis_data == 8'(k) && s1_axis_ready && !s0_axis_ready)) bad++;
    end
    chk("p1_long_frame_intact", bad, 0);
    @(posedge clk); #1;
    s1_axis_valid = 1'b0; s1_axis_last = 1'b0;
    @(negedge clk);
    chk("gap_after_long_frame", {m_axis_valid, s0_axis_ready, s1_axis_ready}, 3'b000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("p0_two_cycles_later", {m_axis_valid, m_axis_data, s0_axis_ready, s1_axis_ready},
        {1'b1, 8'hA0, 1'b1, 1'b0});
    @(posedge clk); #1;
    s0_axis_valid = 1'b0; s0_axis_last = 1'b0;

    // Fill the status FIFO with four single-beat frames; the fifth must wait.
    do_reset();
    s0_axis_valid = 1'b1; s0_axis_last = 1'b1; s0_axis_data = 8'h40;
    beats = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_axis_valid && s0_axis_ready) beats++;
      if (i >= 8 && (m_axis_valid || !busy)) bad++;
      @(posedge clk); #1;
    end
    chk("four_frames_sent", beats, 4);
    chk("fifth_blocked_busy", bad, 0);
    transmit_ok = 1'b1;
    @(posedge clk); #1;
    transmit_ok = 1'b0;
    @(negedge clk);
    chk("ok_status_p0", {s0_status_valid, s1_status_valid, s0_status}, {1'b1, 1'b0, 2'd0});
    got = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (m_axis_valid && s0_axis_ready) begin
        got = 1;
        break;
      end
    end
    chk("fifth_granted", got, 1);
    @(posedge clk); #1;
    s0_axis_valid = 1'b0; s0_axis_last = 1'b0;

    // Status with nothing outstanding.
    do_reset();
    transmit_ok = 1'b1;
    @(posedge clk); #1;
    transmit_ok = 1'b0;
    @(negedge clk);
    chk("stray_set", {stray_status, s0_status_valid, s1_status_valid, busy}, 4'b1000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stray_sticky", stray_status, 1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("stray_cleared", stray_status, 0);
    @(posedge clk); #1;

    // Reset in the middle of a 20-beat frame, then a tie.
    do_reset();
    s0_axis_valid = 1'b1; s0_axis_last = 1'b0; s0_axis_data = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      s0_axis_data = 8'(k);
    end
    @(negedge clk);
    chk("beat5_in_flight", {m_axis_valid, s0_axis_ready}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    s1_axis_valid = 1'b1; s1_axis_data = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_midframe",
        {s0_axis_ready, s1_axis_ready, m_axis_valid, busy, s0_status_valid, s1_status_valid}, 6'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tie_after_rst_p0", {m_axis_valid, s0_axis_ready, s1_axis_ready}, 3'b110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_tx_arbiter.md
AXIS_TX_ARBITER -- requirements
Module: axis_tx_arbiter

Interface
REQ-001 Parameter STATUS_DEPTH, default 4, SHALL set the number of frames whose TransmitStatus may be outstanding (power of 2, at least 2).
REQ-002 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 s0_axis_data / s0_axis_valid / s0_axis_ready / s0_axis_last / s0_axis_err SHALL be requester 0: input 8 / input 1 / output 1 / input 1 / input 1.
REQ-005 s1_axis_* SHALL be requester 1, with the same widths and directions as REQ-004.
REQ-006 m_axis_data / m_axis_valid / m_axis_ready / m_axis_last / m_axis_err SHALL drive the MAC TX stream: output 8 / output 1 / input 1 / output 1 / output 1.
REQ-007 transmit_ok, gave_up, late_collision, underflow  input  1 each  SHALL be the single-cycle TransmitStatus pulses from the MAC.
REQ-008 s0_status_valid, s1_status_valid  output  1  SHALL pulse for one cycle when that requester's oldest frame completes.
REQ-009 s0_status, s1_status  output  2  SHALL encode the result: 0 ok, 1 gave_up, 2 late_collision, 3 underflow.
REQ-010 busy  output  1  SHALL be high while in GRANT or while any status is outstanding.
REQ-011 stray_status  output  1  SHALL be a sticky flag, set by a status pulse arriving with nothing outstanding.

Function
REQ-012 The FSM SHALL have two states, IDLE and GRANT, plus registers gnt (1 bit) and last_port (1 bit).
REQ-013 IDLE: all s*_axis_ready=0 and m_axis_valid=0.
REQ-014 IDLE exit: if any s*_axis_valid=1 and the pending FIFO is not full, the FSM SHALL go to GRANT on the next edge.
- Port selection: gnt = the only valid port; if both are valid, gnt = !last_port.
REQ-015 On the IDLE->GRANT edge, gnt SHALL be pushed into the pending FIFO.
REQ-016 In IDLE with the FIFO full, the FSM SHALL stay in IDLE regardless of requests.
REQ-017 GRANT datapath SHALL be combinational:
- m_axis_{data,valid,last,err} = s[gnt]_axis_*
- s[gnt]_axis_ready = m_axis_ready
- the other port's ready = 0
- zero added latency
REQ-018 In GRANT, a beat with m_axis_valid && m_axis_ready && m_axis_last SHALL set last_port=gnt and return to IDLE on the next edge.
REQ-019 Grant is frame-atomic: the FSM SHALL never switch ports mid-frame, even if the granted port drops valid mid-frame. The MAC reports this as underflow.
REQ-020 Minimum spacing: the first beat of a new frame SHALL occur at least 1 cycle after the previous last beat (the IDLE cycle).
REQ-021 Status decoding: any status input high SHALL pop the FIFO head port P.
- Assert sP_status_valid on the next cycle.
- Priority when several inputs are high in the same cycle: underflow(3) > late_collision(2) > gave_up(1) > ok(0).
REQ-022 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-023 Occupancy arithmetic SHALL be log2(STATUS_DEPTH)+1 bits, with FIFO pointers wrapping modulo STATUS_DEPTH.
REQ-024 A status pulse with the FIFO empty SHALL:
- set stray_status
- assert no s*_status_valid
- leave the FIFO unchanged

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL reset as follows, including mid-frame:
- FSM to IDLE
- gnt=0, last_port=1 (port 0 wins the first tie)
- FIFO emptied
- stray_status=0
- all s*_status_valid=0
- busy=0
REQ-026 All ready and valid outputs SHALL read 0 in the cycle following reset.

Verification
REQ-027 Both ports valid from reset, each sending 3-beat frames, m_axis_ready=1 -> order port 0, 1, 0, 1; one IDLE cycle between frames; data unmodified.
REQ-028 Port 1 frame of 70 beats, with port 0 asserting valid at beat 10 -> no interleave; port 0 starts 2 cycles after port 1's last beat.
REQ-029 STATUS_DEPTH=4, 4 single-beat frames from port 0, no status pulses -> fifth frame blocked and busy=1; one transmit_ok pulse -> s0_status_valid=1 with s0_status=0, then the fifth frame is granted.
REQ-030 Frames in order p0, p1 -> gave_up then late_collision+underflow in the same cycle -> s0_status=1, then s1_status=3.
REQ-031 transmit_ok with nothing outstanding -> stray_status=1 and it stays 1 until rst.
REQ-032 rst asserted at beat 5 of a 20-beat frame -> ready=0 and valid=0 the next cycle, FIFO empty; a later tie grants port 0.
